// File: rtl/nubus_pkg.sv
// NuBus shared definitions: FSM states, size/status codes, TM lane modes.
// Used by both the initiator and the slave side.
package nubus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_RESP = 3'd4
    } nub_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] RSP_COMPLETE = 2'd0;
    localparam logic [1:0] RSP_ERROR    = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT  = 2'd2;
    localparam logic [1:0] RSP_RETRY    = 2'd3;

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_HALF0 = 2'b01;
    localparam logic [1:0] MODE_HALF1 = 2'b11;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } nub_req_t;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b1;
        unique case (1'b1)
            (size == SZ_BYTE): bad = 1'b0;
            (size == SZ_HALF): bad = lo[0];
            (size == SZ_WORD): bad = (lo != 2'b00);
            default:           bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Low two AD bits during the address cycle select the lane.
    function automatic logic [1:0] lane_mode(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [1:0] m;
        m = MODE_WORD;
        unique case (1'b1)
            (size == SZ_BYTE): m = lo;
            (size == SZ_HALF): m = lo[1] ? MODE_HALF1 : MODE_HALF0;
            default:           m = MODE_WORD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nubus_arb_cell.sv
// /ARB drive and slot-ID compare for one NuBus master.
// Lines are open-collector: 1 releases, 0 pulls low.
module nubus_arb_cell (
    input  logic       active,
    input  logic [3:0] idn,
    input  logic [3:0] arbn_i,
    output logic [3:0] arbn_o,
    output logic       win
);

    assign arbn_o = active ? idn : 4'hF;

    // Wired-AND bus equals our own ID only when no higher ID competes.
    assign win = active && (arbn_i == idn);

endmodule

// File: rtl/nubus_initiator.sv
// NuBus single-outstanding master: arbitrate, address, data, respond.
// All state advances on the falling edge of the NuBus clock.
module nubus_initiator
    import nubus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,
    input  logic [3:0]  nub_idn,
    input  logic [31:0] nub_adn_i,
    output logic [31:0] nub_adn_o,
    output logic        nub_adn_oe,
    input  logic        nub_startn_i,
    output logic        nub_startn_o,
    input  logic        nub_ackn_i,
    input  logic        nub_tm1n_i,
    input  logic        nub_tm0n_i,
    output logic        nub_tm1n_o,
    output logic        nub_tm0n_o,
    output logic        nub_tmoe,
    output logic        nub_rqstn_o,
    input  logic [3:0]  nub_arbn_i,
    output logic [3:0]  nub_arbn_o,
    input  logic        req_valid,
    input  logic        req_write,
    output logic        req_ready,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    nub_state_e    state, state_nxt;
    nub_req_t      req_q, req_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          arb_seen_q, arb_seen_nxt;
    logic [31:0]   rdata_q, rdata_nxt;
    logic [1:0]    status_q, status_nxt;
    logic          arb_active;
    logic          arb_win;

    nubus_arb_cell u_arb (
        .active (arb_active),
        .idn    (nub_idn),
        .arbn_i (nub_arbn_i),
        .arbn_o (nub_arbn_o),
        .win    (arb_win)
    );

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            arb_seen_q <= 1'b0;
            rdata_q    <= '0;
            status_q   <= RSP_COMPLETE;
        end else begin
            state      <= state_nxt;
            req_q      <= req_nxt;
            cnt_q      <= cnt_nxt;
            arb_seen_q <= arb_seen_nxt;
            rdata_q    <= rdata_nxt;
            status_q   <= status_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_nxt      = req_q;
        cnt_nxt      = cnt_q;
        arb_seen_nxt = arb_seen_q;
        rdata_nxt    = rdata_q;
        status_nxt   = status_q;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    req_nxt = '{
                        write: req_write,
                        size:  req_size,
                        addr:  req_addr,
                        wdata: req_wdata
                    };
                    arb_seen_nxt = 1'b0;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        rdata_nxt  = '0;
                        status_nxt = RSP_ERROR;
                        state_nxt  = ST_RESP;
                    end else begin
                        state_nxt = ST_ARB;
                    end
                end
            end
            ST_ARB: begin
                // Hold /RQST and /ARB for at least two cycles before a grant.
                arb_seen_nxt = 1'b1;
                if (arb_seen_q && arb_win && nub_startn_i && nub_ackn_i) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_nxt   = '0;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (!nub_ackn_i) begin
                    rdata_nxt  = req_q.write ? 32'h0 : ~nub_adn_i;
                    status_nxt = ~{nub_tm1n_i, nub_tm0n_i};
                    state_nxt  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_nxt  = '0;
                    status_nxt = RSP_TIMEOUT;
                    state_nxt  = ST_RESP;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        nub_startn_o = 1'b1;
        nub_adn_o    = '1;
        nub_adn_oe   = 1'b0;
        nub_tm1n_o   = 1'b1;
        nub_tm0n_o   = 1'b1;
        nub_tmoe     = 1'b0;
        arb_active   = 1'b0;
        unique case (state)
            ST_ARB: begin
                arb_active = 1'b1;
            end
            ST_ADDR: begin
                nub_startn_o = 1'b0;
                nub_adn_oe   = 1'b1;
                nub_adn_o    = ~{req_q.addr[31:2],
                                 lane_mode(req_q.size, req_q.addr[1:0])};
                nub_tm1n_o   = ~req_q.write;
                nub_tm0n_o   = (req_q.size != SZ_BYTE);
                nub_tmoe     = 1'b1;
            end
            ST_DATA: begin
                if (req_q.write) begin
                    nub_adn_oe = 1'b1;
                    nub_adn_o  = ~req_q.wdata;
                end
            end
            default: begin
                arb_active = 1'b0;
            end
        endcase
    end

    assign nub_rqstn_o = ~arb_active;
    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_status  = status_q;

endmodule

// File: tb/tb_nubus_initiator.sv
// Scoreboard bench for nubus_initiator with a simple NuBus responder.
module tb_nubus_initiator;

    logic        nub_clkn;
    logic        nub_resetn;
    logic [3:0]  nub_idn;
    logic [31:0] nub_adn_i;
    logic [31:0] nub_adn_o;
    logic        nub_adn_oe;
    logic        nub_startn_i;
    logic        nub_startn_o;
    logic        nub_ackn_i;
    logic        nub_tm1n_i;
    logic        nub_tm0n_i;
    logic        nub_tm1n_o;
    logic        nub_tm0n_o;
    logic        nub_tmoe;
    logic        nub_rqstn_o;
    logic [3:0]  nub_arbn_i;
    logic [3:0]  nub_arbn_o;
    logic        req_valid;
    logic        req_write;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    logic [3:0]  comp_arbn;
    logic [31:0] resp_ad;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  status;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_rsp = 0;
    int rsp_cyc = 0;
    int issue_cyc = 0;
    int addr_cyc = 0;
    int got_addr = 0;

    int          cfg_delay = 0;
    bit          cfg_addr_ack = 0;
    logic [31:0] cfg_data = '0;
    logic [1:0]  cfg_tmn = 2'b11;

    logic [31:0] cap_addr_ad;
    logic [3:0]  cap_addr_tm;
    logic [4:0]  cap_addr_rel;
    logic [31:0] cap_data_ad;
    logic [2:0]  cap_data_fl;

    nubus_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .nub_clkn     (nub_clkn),
        .nub_resetn   (nub_resetn),
        .nub_idn      (nub_idn),
        .nub_adn_i    (nub_adn_i),
        .nub_adn_o    (nub_adn_o),
        .nub_adn_oe   (nub_adn_oe),
        .nub_startn_i (nub_startn_i),
        .nub_startn_o (nub_startn_o),
        .nub_ackn_i   (nub_ackn_i),
        .nub_tm1n_i   (nub_tm1n_i),
        .nub_tm0n_i   (nub_tm0n_i),
        .nub_tm1n_o   (nub_tm1n_o),
        .nub_tm0n_o   (nub_tm0n_o),
        .nub_tmoe     (nub_tmoe),
        .nub_rqstn_o  (nub_rqstn_o),
        .nub_arbn_i   (nub_arbn_i),
        .nub_arbn_o   (nub_arbn_o),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_ready    (req_ready),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_status   (rsp_status)
    );

    assign nub_arbn_i   = nub_arbn_o & comp_arbn;
    assign nub_startn_i = nub_startn_o;
    assign nub_adn_i    = nub_adn_oe ? nub_adn_o : resp_ad;

    initial nub_clkn = 1'b1;
    always #5 nub_clkn = ~nub_clkn;

    always @(negedge nub_clkn) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every rsp_valid cycle must match the head of the queue.
    always begin
        @(posedge nub_clkn);
        if (rsp_valid) begin
            n_rsp++;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e_mon.rdata);
                check("rsp_status", {30'd0, rsp_status}, {30'd0, e_mon.status});
            end
        end
    end

    // Responder: sees the address cycle, acks after cfg_delay data cycles.
    always begin
        @(posedge nub_clkn);
        if (nub_resetn && !nub_startn_o) begin
            got_addr++;
            addr_cyc = cyc;
            cap_addr_ad = nub_adn_o;
            cap_addr_tm = {nub_tm1n_o, nub_tm0n_o, nub_tmoe, nub_adn_oe};
            cap_addr_rel = {nub_rqstn_o, nub_arbn_o};
            if (cfg_addr_ack) nub_ackn_i = 1'b0;
            for (int k = 0; k <= cfg_delay; k++) begin
                @(posedge nub_clkn);
                if (k == 0) begin
                    cap_data_ad = nub_adn_o;
                    cap_data_fl = {nub_adn_oe, nub_startn_o, nub_tmoe};
                end
                if (k == cfg_delay) begin
                    nub_ackn_i = 1'b0;
                    resp_ad = ~cfg_data;
                    nub_tm1n_i = cfg_tmn[1];
                    nub_tm0n_i = cfg_tmn[0];
                end else begin
                    nub_ackn_i = 1'b1;
                end
            end
            @(posedge nub_clkn);
            nub_ackn_i = 1'b1;
            resp_ad = '1;
            nub_tm1n_i = 1'b1;
            nub_tm0n_i = 1'b1;
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge nub_clkn);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_addr = a;
        req_wdata = wd;
        issue_cyc = cyc;
        @(posedge nub_clkn);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge nub_clkn);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_wait", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_addr(input int g0, input int budget);
        int n = 0;
        while (got_addr == g0 && n < budget) begin
            @(negedge nub_clkn);
            n++;
        end
        if (got_addr == g0) check("addr_wait", 32'd0, 32'd1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge nub_clkn);
    endtask

    task automatic set_resp(input int d, input bit aa, input logic [31:0] data,
                            input logic [1:0] tmn);
        cfg_delay = d;
        cfg_addr_ack = aa;
        cfg_data = data;
        cfg_tmn = tmn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int n0;
        int rel_cyc;
        nub_resetn = 1'b0;
        nub_idn = 4'h5;
        nub_ackn_i = 1'b1;
        nub_tm1n_i = 1'b1;
        nub_tm0n_i = 1'b1;
        comp_arbn = 4'hF;
        resp_ad = '1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'd0;
        req_addr = '0;
        req_wdata = '0;

        settle(3);
        check("rst_bus", {21'd0, nub_startn_o, nub_rqstn_o, nub_arbn_o,
              nub_tm1n_o, nub_tm0n_o, nub_adn_oe, nub_tmoe, rsp_valid},
              {21'd0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check("rst_ad", nub_adn_o, 32'hFFFF_FFFF);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_status", {30'd0, rsp_status}, 32'd0);
        #1 nub_resetn = 1'b1;
        @(posedge nub_clkn);
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Word read, /ACK on first data cycle.
        set_resp(0, 0, 32'hCAFE_F00D, 2'b11);
        exp_q.push_back('{32'hCAFE_F00D, 2'd0});
        issue(1'b0, 2'd2, 32'hF500_0010, 32'd0);
        check("arb_lines", {26'd0, nub_rqstn_o, nub_arbn_o, req_ready},
              {26'd0, 1'b0, 4'h5, 1'b0});
        wait_rsp(40);
        check("rd_addr_ad", cap_addr_ad, ~32'hF500_0010);
        check("rd_addr_tm", {28'd0, cap_addr_tm}, {28'd0, 4'b1111});
        check("rd_addr_rel", {27'd0, cap_addr_rel}, {27'd0, 5'h1F});
        check("rd_data_fl", {29'd0, cap_data_fl}, {29'd0, 3'b010});
        check("arb_lat", issue_cyc + 3, addr_cyc);
        check("rd_lat", addr_cyc + 2, rsp_cyc);
        settle(3);

        // Byte write at lane 3.
        set_resp(0, 0, 32'd0, 2'b11);
        exp_q.push_back('{32'd0, 2'd0});
        issue(1'b1, 2'd0, 32'hF500_0003, 32'h0000_00AB);
        wait_rsp(40);
        check("bw_addr_ad", cap_addr_ad, ~32'hF500_0003);
        check("bw_addr_tm", {28'd0, cap_addr_tm}, {28'd0, 4'b0011});
        check("bw_data_ad", cap_data_ad, ~32'h0000_00AB);
        check("bw_data_fl", {29'd0, cap_data_fl}, {29'd0, 3'b110});
        settle(3);

        // Upper half read, /ACK during ADDR ignored, TM error status.
        set_resp(2, 1, 32'h1234_5678, 2'b10);
        exp_q.push_back('{32'h1234_5678, 2'd1});
        issue(1'b0, 2'd1, 32'h1000_0002, 32'd0);
        wait_rsp(40);
        check("hr_addr_ad", cap_addr_ad, ~32'h1000_0003);
        check("hr_addr_tm", {28'd0, cap_addr_tm}, {28'd0, 4'b1111});
        check("hr_lat", addr_cyc + 4, rsp_cyc);
        settle(4);

        // Lower half write, retry status.
        set_resp(1, 0, 32'd0, 2'b00);
        exp_q.push_back('{32'd0, 2'd3});
        issue(1'b1, 2'd1, 32'h2000_0000, 32'h5555_AAAA);
        wait_rsp(40);
        check("hw_addr_ad", cap_addr_ad, ~32'h2000_0001);
        check("hw_addr_tm", {28'd0, cap_addr_tm}, {28'd0, 4'b0111});
        check("hw_data_ad", cap_data_ad, ~32'h5555_AAAA);
        settle(3);

        // Competing master holds /ARB with a higher ID.
        set_resp(1, 0, 32'h0BAD_BEEF, 2'b11);
        exp_q.push_back('{32'h0BAD_BEEF, 2'd0});
        comp_arbn = 4'hE;
        g0 = got_addr;
        issue(1'b0, 2'd2, 32'h6000_0004, 32'd0);
        repeat (6) begin
            @(posedge nub_clkn);
            check("arb_hold", {30'd0, got_addr == g0, nub_rqstn_o},
                  {30'd0, 1'b1, 1'b0});
        end
        rel_cyc = cyc;
        comp_arbn = 4'hF;
        wait_addr(g0, 10);
        check("arb_release", {31'd0, (addr_cyc - rel_cyc) <= 2}, 32'd1);
        wait_rsp(40);
        check("arb_addr_ad", cap_addr_ad, ~32'h6000_0004);
        settle(3);

        // Misaligned half write and word read: error, no bus cycle.
        g0 = got_addr;
        exp_q.push_back('{32'd0, 2'd1});
        issue(1'b1, 2'd1, 32'h4000_0001, 32'hFFFF_FFFF);
        wait_rsp(10);
        check("mis_lat", issue_cyc + 1, rsp_cyc);
        exp_q.push_back('{32'd0, 2'd1});
        issue(1'b0, 2'd2, 32'h4000_0002, 32'd0);
        wait_rsp(10);
        settle(3);
        check("mis_no_start", got_addr - g0, 0);

        // No /ACK: local timeout, late /ACK must not produce a response.
        set_resp(10, 0, 32'h7777_7777, 2'b11);
        exp_q.push_back('{32'd0, 2'd2});
        n0 = n_rsp;
        issue(1'b0, 2'd2, 32'h3000_0000, 32'd0);
        wait_rsp(60);
        check("to_lat", addr_cyc + 9, rsp_cyc);
        settle(6);
        check("late_ack", n_rsp - n0, 1);

        // Reset asserted during the data phase of a write.
        set_resp(3, 0, 32'd0, 2'b11);
        n0 = n_rsp;
        g0 = got_addr;
        issue(1'b1, 2'd2, 32'h5000_0000, 32'h0F0F_0F0F);
        wait_addr(g0, 20);
        @(posedge nub_clkn);
        check("pre_rst_oe", {31'd0, nub_adn_oe}, 32'd1);
        #1 nub_resetn = 1'b0;
        #1;
        check("mid_rst_bus", {21'd0, nub_startn_o, nub_rqstn_o, nub_arbn_o,
              nub_tm1n_o, nub_tm0n_o, nub_adn_oe, nub_tmoe, rsp_valid},
              {21'd0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check("mid_rst_ad", nub_adn_o, 32'hFFFF_FFFF);
        repeat (2) @(posedge nub_clkn);
        #1 nub_resetn = 1'b1;
        settle(5);
        check("rst_no_rsp", n_rsp - n0, 0);

        // Normal read after the mid-transaction reset.
        set_resp(0, 0, 32'hA5A5_5A5A, 2'b11);
        exp_q.push_back('{32'hA5A5_5A5A, 2'd0});
        issue(1'b0, 2'd2, 32'h7000_0008, 32'd0);
        wait_rsp(40);
        check("post_rst_ad", cap_addr_ad, ~32'h7000_0008);
        check("post_rst_lat", addr_cyc + 2, rsp_cyc);
        settle(3);

        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nubus_initiator.md
NUBUS_INITIATOR -- requirements
Module: nubus_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: DATA-state cycles without /ACK before a local timeout.
REQ-002 nub_clkn  in  1  NuBus clock; all flops update on its falling edge.
REQ-003 nub_resetn  in  1  reset, asynchronous, active-low.
REQ-004 nub_idn  in  4  slot ID, active-low.
REQ-005 nub_adn_i / nub_adn_o / nub_adn_oe  in 32 / out 32 / out 1  AD bus, active-low, split tristate.
REQ-006 nub_startn_i / nub_startn_o  in 1 / out 1  /START sense and drive (1 = released).
REQ-007 nub_ackn_i  in  1  /ACK from responder.
REQ-008 nub_tm1n_i, nub_tm0n_i / nub_tm1n_o, nub_tm0n_o, nub_tmoe  in 1 each / out 1 each  transfer mode and status lines.
REQ-009 nub_rqstn_o  out  1  /RQST, open-collector (0 = drive, 1 = release).
REQ-010 nub_arbn_i / nub_arbn_o  in 4 / out 4  /ARB sense and open-collector drive.
REQ-011 req_valid, req_write  in 1 each; req_ready out 1; req_size in 2 (0 byte, 1 half, 2 word); req_addr in 32; req_wdata in 32.
REQ-012 rsp_valid  out 1; rsp_rdata  out 32; rsp_status  out 2 (0 complete, 1 error, 2 timeout, 3 retry).

Function
REQ-013 FSM states: IDLE, ARB, ADDR, DATA, RESP.
REQ-014 IDLE: req_ready=1; on req_valid&req_ready, latch request, go ARB.
REQ-015 Misaligned request (half with addr[0]=1, word with addr[1:0]!=0): no bus activity; go RESP with status 1, rdata 0.
REQ-016 ARB: drive nub_rqstn_o=0 and nub_arbn_o=nub_idn; count ≥2 cycles, then grant when nub_arbn_i==nub_idn, nub_startn_i=1 and nub_ackn_i=1 on the same edge; otherwise stay.
REQ-017 ADDR, exactly one cycle: nub_startn_o=0; nub_adn_oe=1; AD = inverted {addr[31:2], mode[1:0]}; tm1 asserted (tm1n=0) for write; tm0 asserted for byte; mode = byte lane for byte, 01/11 for half0/half1, 00 for word; nub_tmoe=1; release /RQST and /ARB.
REQ-018 DATA: nub_startn_o=1; nub_tmoe=0; write drives AD = ~wdata (oe=1); read releases AD (oe=0); cycle counter increments each cycle.
REQ-019 /ACK sampled low in DATA: rsp_rdata = ~nub_adn_i for reads, 0 for writes; rsp_status = ~{nub_tm1n_i, nub_tm0n_i}; go RESP.
REQ-020 Counter reaching TIMEOUT_CYCLES without /ACK: status 2, rdata 0, go RESP; late /ACK ignored.
REQ-021 RESP: rsp_valid=1 for exactly one cycle, rsp_* stable while valid; release AD; go IDLE.
REQ-022 Latency: granted read with /ACK on first DATA cycle gives rsp_valid 3 cycles after ARB exit.
REQ-023 /ACK asserted on the ADDR cycle is ignored.
REQ-024 req_ready=0 in all states except IDLE; one outstanding transaction only.

Reset
REQ-025 Reset: state IDLE; all active-low outputs 1; nub_adn_oe=0, nub_tmoe=0; rsp_valid=0; rsp_rdata=0; rsp_status=0; counter 0; req_ready=1 after release.
REQ-026 Reset mid-transaction releases all bus lines immediately; no response is issued.

Structure
REQ-027 Shared package nubus_pkg holds FSM state enum, size codes, status codes and TM encodings, reused by the slave side.
REQ-028 One sub-module, nubus_arb_cell: /ARB drive and ID-compare logic.

Verification
REQ-029 Word read 0xF5000010, responder /ACK first DATA cycle with AD=~0xCAFEF00D, TM status 0 -> rsp_rdata 0xCAFEF00D, status 0, AD oe=0 in DATA.
REQ-030 Byte write addr 0xF5000003, wdata 0x000000AB -> ADDR AD=~0xF5000003, tm1n=0, tm0n=0; DATA AD=~0x000000AB.
REQ-031 Competing ID 0xE held on /ARB, own ID 0x5 -> stays in ARB with /RQST low; release competitor -> ADDR within 2 cycles.
REQ-032 No /ACK, TIMEOUT_CYCLES=8 -> rsp_status 2 after 8 DATA cycles; subsequent /ACK produces no rsp_valid.
REQ-033 Half write addr 0x...1 -> immediate status 1, nub_startn_o never low.
REQ-034 Reset asserted in DATA -> all outputs released same cycle; no rsp_valid; next request completes normally.
